ge_link_monitor: RTL and testbench

- Multi-channel gigabit-link indication monitor. Per channel: synchronises a PHY GE indication pin, debounces link-up, holds gigabit mode for a programmable time after link-down, and reports status, up-event counts and sticky change flags.
- ge_mode[i] is the glitch-free select for the per-channel GMII TX clock mux: 1 selects the local 125 MHz clock, 0 selects the PHY TXCLK.
- Sits beside the PS GEM wrappers in the top level and runs in the 125 MHz PLL domain.

---
 rtl/ge_link_pkg.sv | 15 +
 rtl/ge_link_chan.sv | 114 +++++++++++
 rtl/ge_link_monitor.sv | 59 +++++
 tb/tb_ge_link_monitor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ge_link_pkg.sv
// Shared definitions for the gigabit-link indication monitor.
// Holds the per-channel state encoding and the default timing limits.
package ge_link_pkg;

    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_QUAL = 2'd1,
        ST_UP   = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam int unsigned DEF_DEB_CYCLES  = 16;
    localparam int unsigned DEF_HOLD_CYCLES = 16777215;

endpackage

// File: rtl/ge_link_chan.sv
// One monitor channel: 2-flop synchroniser, debounce/hold FSM, timer,
// saturating link-up counter and sticky change flag.
// Ports: clk, rst (async high), ge_ind (raw pin), flag_clr (pulse),
//        ge_mode (clock select), change_flag (sticky), link_up_cnt.
module ge_link_chan
    import ge_link_pkg::*;
#(
    parameter int unsigned TMR_W           = 28,
    parameter int unsigned DEB_CYCLES      = DEF_DEB_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned IND_ACTIVE_HIGH = 1,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ge_ind,
    input  logic             flag_clr,
    output logic             ge_mode,
    output logic             change_flag,
    output logic [CNT_W-1:0] link_up_cnt
);

    localparam logic [TMR_W-1:0] DEB_LAST  = TMR_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic             IND_INV   = (IND_ACTIVE_HIGH == 0);

    logic             sync1_q;
    logic             sync2_q;
    logic             ind;
    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             mode_q, mode_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Polarity is applied after the synchroniser so both flops reset to 0.
    assign ind = sync2_q ^ IND_INV;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_DOWN: begin
                if (ind) begin
                    state_d = ST_QUAL;
                    timer_d = '0;
                end
            end
            ST_QUAL: begin
                if (!ind) begin
                    state_d = ST_DOWN;
                end else if (timer_q == DEB_LAST) begin
                    state_d = ST_UP;
                    mode_d  = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_UP: begin
                if (!ind) begin
                    state_d = ST_HOLD;
                    timer_d = '0;
                end
            end
            ST_HOLD: begin
                if (ind) begin
                    state_d = ST_UP;
                    timer_d = '0;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = ST_DOWN;
                    mode_d  = 1'b0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_DOWN;
            end
        endcase
        // A toggle in the same cycle as a clear keeps the flag set.
        flag_d = (mode_d != mode_q) | (flag_q & ~flag_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_DOWN;
            timer_q <= '0;
            mode_q  <= 1'b0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ge_ind;
            sync2_q <= sync1_q;
            state_q <= state_d;
            timer_q <= timer_d;
            mode_q  <= mode_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ge_mode     = mode_q;
    assign change_flag = flag_q;
    assign link_up_cnt = cnt_q;

endmodule

// File: rtl/ge_link_monitor.sv
// Multi-channel gigabit-link monitor: one independent ge_link_chan per
// channel, packed counters and a registered any-link-up summary.
// Ports: clk, rst (async high), ge_ind[CH], flag_clr[CH], ge_mode[CH],
//        change_flag[CH], link_up_cnt[CH*CNT_W] (ch i at i*CNT_W), any_up.
module ge_link_monitor
    import ge_link_pkg::*;
#(
    parameter int unsigned CHANNELS        = 1,
    parameter int unsigned TMR_W           = 28,
    parameter int unsigned DEB_CYCLES      = DEF_DEB_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned IND_ACTIVE_HIGH = 1,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       ge_ind,
    input  logic [CHANNELS-1:0]       flag_clr,
    output logic [CHANNELS-1:0]       ge_mode,
    output logic [CHANNELS-1:0]       change_flag,
    output logic [CHANNELS*CNT_W-1:0] link_up_cnt,
    output logic                      any_up
);

    logic any_up_q, any_up_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        ge_link_chan #(
            .TMR_W           (TMR_W),
            .DEB_CYCLES      (DEB_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .IND_ACTIVE_HIGH (IND_ACTIVE_HIGH),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .ge_ind      (ge_ind[i]),
            .flag_clr    (flag_clr[i]),
            .ge_mode     (ge_mode[i]),
            .change_flag (change_flag[i]),
            .link_up_cnt (link_up_cnt[i*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        any_up_d = |ge_mode;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_up_q <= 1'b0;
        end else begin
            any_up_q <= any_up_d;
        end
    end

    assign any_up = any_up_q;

endmodule

// File: tb/tb_ge_link_monitor.sv
// Bench for ge_link_monitor: directed scenarios then random stimulus,
// compared against a run-length reference model, both polarities.
module tb_ge_link_monitor;

    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] ge_ind = 2'b00;
    logic [1:0] flag_clr = 2'b00;
    logic [1:0] mode_p, flag_p, mode_n, flag_n;
    logic [3:0] cnt_p, cnt_n;
    logic       any_p, any_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ge_link_monitor #(
        .CHANNELS(2), .TMR_W(28), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .IND_ACTIVE_HIGH(1), .CNT_W(2)
    ) dut_p (
        .clk(clk), .rst(rst), .ge_ind(ge_ind), .flag_clr(flag_clr),
        .ge_mode(mode_p), .change_flag(flag_p), .link_up_cnt(cnt_p),
        .any_up(any_p)
    );

    ge_link_monitor #(
        .CHANNELS(2), .TMR_W(28), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .IND_ACTIVE_HIGH(0), .CNT_W(2)
    ) dut_n (
        .clk(clk), .rst(rst), .ge_ind(ge_ind), .flag_clr(flag_clr),
        .ge_mode(mode_n), .change_flag(flag_n), .link_up_cnt(cnt_n),
        .any_up(any_n)
    );

    // Reference model, index [inst][ch]; inst 0 active-high, 1 active-low.
    // Link state is derived from run lengths of the sampled indication:
    // DEB+1 consecutive active samples bring the link up, HOLD+1
    // consecutive inactive samples take it down.
    bit h1[2][2], h2[2][2];
    bit mode_m[2][2], flag_m[2][2];
    int run1[2][2], run0[2][2], cnt_m[2][2];
    bit any_m[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            any_m[m] = 0;
            for (int c = 0; c < 2; c++) begin
                h1[m][c] = 0; h2[m][c] = 0;
                mode_m[m][c] = 0; flag_m[m][c] = 0;
                run1[m][c] = 0; run0[m][c] = 0; cnt_m[m][c] = 0;
            end
        end
    endtask

    task automatic model_edge(input logic [1:0] gi, input logic [1:0] clr);
        bit samp, pm;
        for (int m = 0; m < 2; m++) begin
            any_m[m] = mode_m[m][0] | mode_m[m][1];
            for (int c = 0; c < 2; c++) begin
                samp = h2[m][c] ^ (m == 1);
                h2[m][c] = h1[m][c];
                h1[m][c] = gi[c];
                pm = mode_m[m][c];
                if (samp) begin
                    run1[m][c]++; run0[m][c] = 0;
                end else begin
                    run0[m][c]++; run1[m][c] = 0;
                end
                if (!pm && run1[m][c] == DEB + 1) begin
                    mode_m[m][c] = 1;
                    if (cnt_m[m][c] < 3) cnt_m[m][c]++;
                end
                if (pm && run0[m][c] == HOLD + 1) mode_m[m][c] = 0;
                if (mode_m[m][c] != pm) flag_m[m][c] = 1;
                else if (clr[c]) flag_m[m][c] = 0;
            end
        end
    endtask

    task automatic expect_eq(input string tag, input logic [3:0] obs,
                             input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp,
                   $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] em, ef;
        logic [3:0] ec;
        for (int m = 0; m < 2; m++) begin
            em = {mode_m[m][1], mode_m[m][0]};
            ef = {flag_m[m][1], flag_m[m][0]};
            ec = {2'(cnt_m[m][1]), 2'(cnt_m[m][0])};
            if (m == 0) begin
                expect_eq({tag, "/p_mode"}, 4'(mode_p), 4'(em));
                expect_eq({tag, "/p_flag"}, 4'(flag_p), 4'(ef));
                expect_eq({tag, "/p_cnt"}, cnt_p, ec);
                expect_eq({tag, "/p_any"}, 4'(any_p), 4'(any_m[0]));
            end else begin
                expect_eq({tag, "/n_mode"}, 4'(mode_n), 4'(em));
                expect_eq({tag, "/n_flag"}, 4'(flag_n), 4'(ef));
                expect_eq({tag, "/n_cnt"}, cnt_n, ec);
                expect_eq({tag, "/n_any"}, 4'(any_n), 4'(any_m[1]));
            end
        end
    endtask

    // Inputs are driven 1 time unit after an edge; sample at edge+1.
    task automatic tick();
        logic [1:0] gi, fc;
        gi = ge_ind;
        fc = flag_clr;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(gi, fc);
        #1;
    endtask

    task automatic step(input string tag);
        tick();
        check_all(tag);
    endtask

    task automatic async_reset(input int cycles);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        for (int k = 0; k < cycles; k++) step("in_rst");
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        // Reset with both indications high, then timed rise.
        ge_ind = 2'b11;
        rst = 1'b1;
        #1;
        check_all("rst0");
        expect_eq("rst_mode", 4'(mode_p), 4'h0);
        expect_eq("rst_cnt", cnt_p, 4'h0);
        for (int k = 0; k < 3; k++) step("rst_hold");
        expect_eq("rst_any", 4'(any_p), 4'h0);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step("rise");
            if (e == 6) expect_eq("rise_e6", 4'(mode_p[0]), 4'h0);
        end
        expect_eq("rise_e7", 4'(mode_p[0]), 4'h1);
        expect_eq("rise_cnt0", 4'(cnt_p[1:0]), 4'h1);
        expect_eq("rise_flag0", 4'(flag_p[0]), 4'h1);
        step("settle");
        flag_clr = 2'b11;
        step("clr");
        flag_clr = 2'b00;
        expect_eq("clr_flag", 4'(flag_p), 4'h0);

        // Hold bridge: 8-cycle drop on ch0.
        ge_ind[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step("bridge");
            expect_eq("bridge_mode", 4'(mode_p[0]), 4'h1);
        end
        ge_ind[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step("bridge_back");
            expect_eq("bridge_mode2", 4'(mode_p[0]), 4'h1);
        end
        expect_eq("bridge_cnt", 4'(cnt_p[1:0]), 4'h1);
        expect_eq("bridge_flag", 4'(flag_p[0]), 4'h0);

        // Hold expiry: drop both; ch0 falls at edge 13, any_up one later.
        ge_ind = 2'b00;
        for (int e = 1; e <= 13; e++) begin
            step("expiry");
            if (e == 12) expect_eq("exp_e12", 4'(mode_p[0]), 4'h1);
        end
        expect_eq("exp_e13", 4'(mode_p[0]), 4'h0);
        expect_eq("exp_flag", 4'(flag_p[0]), 4'h1);
        expect_eq("exp_any13", 4'(any_p), 4'h1);
        step("expiry");
        expect_eq("exp_any14", 4'(any_p), 4'h0);
        flag_clr = 2'b11;
        step("clr2");
        flag_clr = 2'b00;

        // Debounce reject: 3-cycle pulse on ch0.
        ge_ind[0] = 1'b1;
        for (int k = 0; k < 3; k++) step("deb");
        ge_ind[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step("deb_rej");
            expect_eq("deb_mode", 4'(mode_p[0]), 4'h0);
        end
        expect_eq("deb_cnt", 4'(cnt_p[1:0]), 4'h1);
        expect_eq("deb_flag", 4'(flag_p[0]), 4'h0);

        // Saturation on ch1 with flag_clr racing each toggle.
        for (int i = 0; i < 5; i++) begin
            ge_ind[1] = 1'b1;
            for (int e = 1; e <= 7; e++) begin
                flag_clr = (e == 7) ? 2'b10 : 2'b00;
                step("sat_up");
            end
            flag_clr = 2'b00;
            expect_eq("sat_up_mode", 4'(mode_p[1]), 4'h1);
            expect_eq("sat_up_flag", 4'(flag_p[1]), 4'h1);
            ge_ind[1] = 1'b0;
            for (int e = 1; e <= 13; e++) begin
                flag_clr = (e == 13) ? 2'b10 : 2'b00;
                step("sat_dn");
            end
            flag_clr = 2'b00;
            expect_eq("sat_dn_mode", 4'(mode_p[1]), 4'h0);
            expect_eq("sat_dn_flag", 4'(flag_p[1]), 4'h1);
        end
        expect_eq("sat_cnt1", 4'(cnt_p[3:2]), 4'h3);

        // Active-low polarity: ge_ind held low through reset.
        ge_ind = 2'b00;
        async_reset(2);
        for (int e = 1; e <= 7; e++) begin
            step("pol");
            expect_eq("pol_same", 4'(mode_n[0]), 4'(mode_n[1]));
        end
        expect_eq("pol_mode", 4'(mode_n), 4'h3);
        expect_eq("pol_p_mode", 4'(mode_p), 4'h0);

        // Random segments with random clears and occasional resets.
        for (int s = 0; s < 200; s++) begin
            int len;
            ge_ind = 2'($urandom);
            len = $urandom_range(1, 18);
            for (int k = 0; k < len; k++) begin
                flag_clr = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
                if ($urandom_range(0, 299) == 0) async_reset(1);
                step("rand");
            end
        end
        flag_clr = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
